// File: rtl/sram_like_arbiter.sv
// Two-channel SRAM-like bus arbiter: merges an instruction read port and a data read/write port
// onto one shared bus, tracking in-flight requests in a tag FIFO so responses route back in order.
module sram_like_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_OUT  = 4,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    // instruction channel
    input  logic                             i_req,
    input  logic [ADDR_W-1:0]                i_addr,
    output logic                             i_addr_ok,
    output logic                             i_data_ok,
    output logic [DATA_W-1:0]                i_rdata,
    // data channel
    input  logic                             d_req,
    input  logic                             d_wr,
    input  logic [DATA_W/8-1:0]              d_wstrb,
    input  logic [ADDR_W-1:0]                d_addr,
    input  logic [DATA_W-1:0]                d_wdata,
    output logic                             d_addr_ok,
    output logic                             d_data_ok,
    output logic [DATA_W-1:0]                d_rdata,
    // shared memory-side bus
    output logic                             m_req,
    output logic                             m_wr,
    output logic [DATA_W/8-1:0]              m_wstrb,
    output logic [ADDR_W-1:0]                m_addr,
    output logic [DATA_W-1:0]                m_wdata,
    input  logic                             m_addr_ok,
    input  logic                             m_data_ok,
    input  logic [DATA_W-1:0]                m_rdata,
    // status
    output logic [$clog2(MAX_OUT):0]         outstanding,
    output logic                             err
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PTR_W  = $clog2(MAX_OUT);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_LOCK_I = 2'd1;
    localparam logic [1:0] ST_LOCK_D = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               rr_data_q, rr_data_d;
    logic [MAX_OUT-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic full;
    logic empty;
    logic sel_data;
    logic gnt_i;
    logic gnt_d;
    logic bus_req;
    logic bus_acc;
    logic push;
    logic pop;
    logic head;

    assign full  = (cnt_q == CNT_W'(MAX_OUT));
    assign empty = (cnt_q == '0);
    assign head  = tag_q[rd_ptr_q];

    // A held lock keeps its channel until accept; a dropped req falls back to normal arbitration.
    always_comb begin
        sel_data = 1'b0;
        if (state_q == ST_LOCK_D && d_req) begin
            sel_data = 1'b1;
        end else if (state_q == ST_LOCK_I && i_req) begin
            sel_data = 1'b0;
        end else if (ARB_MODE == 0) begin
            sel_data = d_req;
        end else begin
            sel_data = d_req & (~i_req | rr_data_q);
        end
    end

    assign gnt_d   = d_req & sel_data;
    assign gnt_i   = i_req & ~sel_data;
    assign bus_req = (i_req | d_req) & ~full;
    assign bus_acc = bus_req & m_addr_ok;
    assign push    = bus_acc;
    assign pop     = m_data_ok & ~empty;

    // Next-state: lock tracking, round-robin pointer, tag FIFO and sticky error.
    always_comb begin
        state_d   = state_q;
        rr_data_d = rr_data_q;
        tag_d     = tag_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        case (state_q)
            ST_FREE, ST_LOCK_I, ST_LOCK_D: begin
                if (bus_req && !m_addr_ok) begin
                    state_d = sel_data ? ST_LOCK_D : ST_LOCK_I;
                end else begin
                    state_d = ST_FREE;
                end
            end
            default: state_d = ST_FREE;
        endcase

        if (ARB_MODE != 0 && bus_acc) begin
            rr_data_d = ~sel_data;
        end

        if (push) begin
            tag_d[wr_ptr_q] = sel_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (m_data_ok && empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FREE;
            rr_data_q <= 1'b1;
            tag_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_data_q <= rr_data_d;
            tag_q     <= tag_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // Zero-latency request and response paths; everything is forced low while reset is high.
    assign m_req     = bus_req & ~reset;
    assign m_wr      = gnt_d & d_wr & ~reset;
    assign m_wstrb   = (gnt_d && d_wr && !reset) ? d_wstrb : STRB_W'(0);
    assign m_addr    = reset ? ADDR_W'(0) : (sel_data ? d_addr : i_addr);
    assign m_wdata   = (gnt_d && !reset) ? d_wdata : DATA_W'(0);

    assign i_addr_ok = gnt_i & m_addr_ok & ~full & ~reset;
    assign d_addr_ok = gnt_d & m_addr_ok & ~full & ~reset;

    assign i_data_ok = pop & ~head & ~reset;
    assign d_data_ok = pop & head & ~reset;
    assign i_rdata   = reset ? DATA_W'(0) : m_rdata;
    assign d_rdata   = reset ? DATA_W'(0) : m_rdata;

    assign outstanding = reset ? CNT_W'(0) : cnt_q;
    assign err         = err_q & ~reset;

endmodule
